// File: rtl/dcache_2way_wb.sv
// L1 data cache: 2-way set-associative, write-back, write-allocate, 256-bit lines.
// Optional DCACHE_PERF_CNT_EN adds hit/miss/writeback event counters.
module dcache_2way_wb #(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned WAYS    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_mbe,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [31:0]  wb_count
`endif
);

  localparam int unsigned SETS    = 1 << S_INDEX;
  localparam int unsigned LADDR_W = 32 - 5;
  localparam int unsigned TAG_W   = LADDR_W - S_INDEX;
  localparam int unsigned LINE_W  = 256;

  if (WAYS != 2) begin : g_bad_ways
    $fatal(1, "dcache_2way_wb: WAYS must be 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [SETS-1:0]           lru_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]         data_q [SETS][WAYS];

  logic [LADDR_W-1:0] miss_line_q;
  logic               victim_q;

  logic [S_INDEX-1:0] set_c;
  logic [TAG_W-1:0]   tag_c;
  logic [2:0]         word_c;
  logic               req_c;
  logic               h0_c;
  logic               h1_c;
  logic               hit_c;
  logic               hit_way_c;
  logic               victim_c;
  logic               victim_dirty_c;
  logic               miss_start_c;
  logic               fill_done_c;
  logic [S_INDEX-1:0] mset_c;
  logic [TAG_W-1:0]   mtag_c;
  logic [LINE_W-1:0]  hit_line_c;
  logic [31:0]        old_word_c;
  logic [31:0]        wmerge_c;
  logic               unused_c;

  assign unused_c = ^mem_address[1:0];

  // Request decode against the current set
  assign set_c     = mem_address[S_INDEX+4:5];
  assign tag_c     = mem_address[31:S_INDEX+5];
  assign word_c    = mem_address[4:2];
  assign req_c     = mem_read | mem_write;
  assign h0_c      = valid_q[set_c][0] && (tag_q[set_c][0] == tag_c);
  assign h1_c      = valid_q[set_c][1] && (tag_q[set_c][1] == tag_c);
  assign hit_c     = (state_q == S_IDLE) && req_c && (h0_c || h1_c);
  assign hit_way_c = ~h0_c;
  assign hit_line_c = data_q[set_c][hit_way_c];
  assign old_word_c = hit_line_c[{word_c, 5'b0} +: 32];

  // Invalid ways are filled before anything is evicted, way0 first
  assign victim_c       = !valid_q[set_c][0] ? 1'b0 :
                          !valid_q[set_c][1] ? 1'b1 : lru_q[set_c];
  assign victim_dirty_c = valid_q[set_c][victim_c] && dirty_q[set_c][victim_c];

  // Miss handling works from the line address captured when the miss was seen
  assign mset_c      = miss_line_q[S_INDEX-1:0];
  assign mtag_c      = miss_line_q[LADDR_W-1:S_INDEX];
  assign fill_done_c = (state_q == S_FILL) && pmem_resp;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wmerge_c[b*8 +: 8] = mem_mbe[b] ? mem_wdata[b*8 +: 8] : old_word_c[b*8 +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    miss_start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          mem_resp  = 1'b1;
          mem_rdata = old_word_c;
        end else if (req_c) begin
          miss_start_c = 1'b1;
          state_d      = victim_dirty_c ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[mset_c][victim_q], mset_c, 5'b0};
        pmem_wdata   = data_q[mset_c][victim_q];
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mtag_c, mset_c, 5'b0};
        if (pmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, status bits and miss bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      lru_q       <= '0;
      miss_line_q <= '0;
      victim_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start_c) begin
        miss_line_q <= mem_address[31:5];
        victim_q    <= victim_c;
      end
      if (hit_c) begin
        lru_q[set_c] <= ~hit_way_c;
        if (mem_write) dirty_q[set_c][hit_way_c] <= 1'b1;
      end
      if (fill_done_c) begin
        valid_q[mset_c][victim_q] <= 1'b1;
        dirty_q[mset_c][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (hit_c && mem_write) data_q[set_c][hit_way_c][{word_c, 5'b0} +: 32] <= wmerge_c;
    if (fill_done_c) begin
      data_q[mset_c][victim_q] <= pmem_rdata;
      tag_q[mset_c][victim_q]  <= mtag_c;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_c) hit_count <= hit_count + 32'd1;
      if (miss_start_c) miss_count <= miss_count + 32'd1;
      if ((state_q == S_WB) && pmem_resp) wb_count <= wb_count + 32'd1;
    end
  end
`endif

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Bench for dcache_2way_wb: transaction-level cache/memory model with a latency-programmable pmem.
module tb_dcache_2way_wb;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_mbe;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [31:0]  wb_count;
`endif

  dcache_2way_wb dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  int tests;
  int fails;
  int lat;
  int mcnt;
  int exp_hit;
  int exp_miss;
  int exp_wb;

  logic [31:0] pm   [int unsigned];
  logic [31:0] gold [int unsigned];
  int unsigned rd_q[$];
  int unsigned wr_q[$];

  // Cache model: per set, which tags live in which way and which way goes next
  bit          mv  [8][2];
  bit          md  [8][2];
  int unsigned mt  [8][2];
  int          mev [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pm_word(int unsigned a);
    if (pm.exists(a)) return pm[a];
    return 32'(a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] gold_word(int unsigned a);
    if (gold.exists(a)) return gold[a];
    return pm_word(a);
  endfunction

  // Physical memory: answers a held request after lat cycles with a one-cycle pulse
  always @(negedge clk) begin
    logic [255:0] line_v;
    pmem_resp = 1'b0;
    if (!rst) begin
      mcnt = 0;
    end else if (pmem_read || pmem_write) begin
      tests++;
      if (pmem_read && pmem_write) begin
        fails++;
        $display("FAIL pmem_excl: read=%b write=%b, required not both", pmem_read, pmem_write);
      end
      mcnt++;
      if (mcnt >= lat) begin
        mcnt = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          for (int w = 0; w < 8; w++) begin
            tests++;
            if (pmem_wdata[w*32 +: 32] !== gold_word(pmem_address + 32'(4*w))) begin
              fails++;
              $display("FAIL wb_data @%h: got %h exp %h", pmem_address + 32'(4*w),
                       pmem_wdata[w*32 +: 32], gold_word(pmem_address + 32'(4*w)));
            end
            pm[pmem_address + 32'(4*w)] = pmem_wdata[w*32 +: 32];
          end
          wr_q.push_back(pmem_address);
        end else begin
          for (int w = 0; w < 8; w++) line_v[w*32 +: 32] = pm_word(pmem_address + 32'(4*w));
          pmem_rdata = line_v;
          rd_q.push_back(pmem_address);
        end
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mev[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = 0;
      end
    end
    gold.delete();
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
  endtask

  task automatic model_access(input int unsigned a, input bit wr, output bit hit, output bit wb,
                              output int unsigned wb_line, output int unsigned fill_line);
    int unsigned s;
    int unsigned tg;
    int way;
    s = (a >> 5) & 7; tg = a >> 8;
    hit = 0; wb = 0; way = 0; wb_line = 0; fill_line = 0;
    for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == tg && !hit) begin hit = 1; way = w; end
    if (!hit) begin
      way = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : mev[s]);
      wb = mv[s][way] && md[s][way];
      wb_line = (mt[s][way] << 8) | (s << 5);
      fill_line = a & ~32'd31;
      mv[s][way] = 1'b1; mt[s][way] = tg; md[s][way] = 1'b0;
      exp_miss++;
      if (wb) exp_wb++;
    end
    exp_hit++;
    mev[s] = 1 - way;
    if (wr) md[s][way] = 1'b1;
  endtask

  // One held request from drive to mem_resp; checks latency, load data and pmem traffic
  task automatic do_access(input string nm, input int unsigned a, input bit wr, input logic [31:0] wd,
                           input logic [3:0] be, output int cyc, output logic [31:0] rd);
    bit hit, wb, got;
    int unsigned wb_line, fill_line;
    int exp_cyc;
    logic [31:0] exp_rd, nw;
    exp_rd = gold_word(a);
    model_access(a, wr, hit, wb, wb_line, fill_line);
    exp_cyc = hit ? 1 : (2 + lat + (wb ? lat : 0));
    rd_q.delete(); wr_q.delete();
    mem_address = a; mem_read = !wr; mem_write = wr; mem_wdata = wd; mem_mbe = be;
    cyc = 0; got = 0; rd = '0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mem_resp === 1'b1) begin got = 1; rd = mem_rdata; end
      else begin @(posedge clk); #1; end
    end
    if (got) begin @(posedge clk); #1; end
    mem_read = 1'b0; mem_write = 1'b0;
    if (wr) begin
      nw = gold_word(a);
      for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
      gold[a] = nw;
    end
    tests++;
    if (!got || cyc != exp_cyc) begin
      fails++;
      $display("FAIL %s latency @%h: got %0d cycles (resp=%0d) exp %0d", nm, a, cyc, got, exp_cyc);
    end
    if (!wr) begin
      tests++;
      if (rd !== exp_rd) begin
        fails++;
        $display("FAIL %s rdata @%h: got %h exp %h", nm, a, rd, exp_rd);
      end
    end
    tests++;
    if (rd_q.size() != (hit ? 0 : 1) || (!hit && rd_q[0] != fill_line)) begin
      fails++;
      $display("FAIL %s fills @%h: got %0d reads exp %0d to %h", nm, a, rd_q.size(), hit ? 0 : 1, fill_line);
    end
    tests++;
    if (wr_q.size() != (wb ? 1 : 0) || (wb && wr_q[0] != wb_line)) begin
      fails++;
      $display("FAIL %s writebacks @%h: got %0d exp %0d to %h", nm, a, wr_q.size(), wb ? 1 : 0, wb_line);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_mbe = '0; pmem_rdata = '0; pmem_resp = 1'b0; lat = 5; mcnt = 0;
    model_reset();
    #12;
    tests++; if (mem_resp !== 1'b0) begin fails++; $display("FAIL rst mem_resp: got %b exp 0", mem_resp); end
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL rst pmem_read: got %b exp 0", pmem_read); end
    tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL rst pmem_write: got %b exp 0", pmem_write); end
    tests++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL rst mem_rdata: got %h exp 0", mem_rdata); end
    tests++; if (pmem_address !== 32'h0) begin fails++; $display("FAIL rst pmem_address: got %h exp 0", pmem_address); end
    tests++; if (pmem_wdata !== 256'h0) begin fails++; $display("FAIL rst pmem_wdata: nonzero, exp 0"); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    int cyc; logic [31:0] rd;
    lat = 5;
    pm[32'h104] = 32'hDEAD_BEEF;
    do_access("cold_read", 32'h104, 1'b0, '0, '0, cyc, rd);
    tests++; if (cyc != 7) begin fails++; $display("FAIL cold_read cycle: got %0d exp 7", cyc); end
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL cold_read data: got %h exp deadbeef", rd); end
  endtask

  task automatic test_write_merge();
    int cyc; logic [31:0] rd;
    lat = 3;
    do_access("wr_merge", 32'h104, 1'b1, 32'h00AB_0000, 4'b0100, cyc, rd);
    tests++; if (cyc != 1) begin fails++; $display("FAIL wr_hit cycle: got %0d exp 1", cyc); end
    do_access("wr_readback", 32'h104, 1'b0, '0, '0, cyc, rd);
    tests++; if (rd !== 32'hDEAB_BEEF) begin fails++; $display("FAIL wr_readback data: got %h exp deabbeef", rd); end
  endtask

  task automatic test_evict();
    int cyc; logic [31:0] rd;
    lat = 4;
    do_access("evict_a", 32'h104, 1'b0, '0, '0, cyc, rd);
    do_access("evict_b", 32'h1104, 1'b0, '0, '0, cyc, rd);
    do_access("evict_c", 32'h2104, 1'b0, '0, '0, cyc, rd);
    tests++;
    if (wr_q.size() != 1 || rd_q.size() != 1 || wr_q[0] != 32'h100 || rd_q[0] != 32'h2100) begin
      fails++;
      $display("FAIL evict traffic: got %0d wb %0d fill, exp wb 100 then fill 2100", wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_alternate();
    int cyc; logic [31:0] rd;
    lat = 2;
    do_access("alt_prime0", 32'h104, 1'b0, '0, '0, cyc, rd);
    do_access("alt_prime1", 32'h1104, 1'b0, '0, '0, cyc, rd);
    for (int i = 0; i < 8; i++) begin
      do_access("alternate", (i % 2 == 0) ? 32'h104 : 32'h1104, 1'b0, '0, '0, cyc, rd);
      tests++;
      if (cyc != 1 || rd_q.size() != 0 || wr_q.size() != 0) begin
        fails++;
        $display("FAIL alternate %0d: got %0d cycles %0d pmem ops, exp 1 cycle none", i, cyc, rd_q.size() + wr_q.size());
      end
    end
  endtask

  task automatic test_random();
    int cyc; logic [31:0] rd;
    int unsigned a;
    bit wr;
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(1, 6);
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      wr = 1'($urandom_range(0, 1));
      do_access("random", a, wr, $urandom, 4'($urandom_range(0, 15)), cyc, rd);
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc, n; logic [31:0] rd;
    lat = 8;
    mem_address = 32'h4104; mem_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (pmem_read !== 1'b1 && n < 100);
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL rst_fill reach: no fill within %0d cycles", n); end
    #2 rst = 1'b0;
    #1;
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL rst_fill pmem_read: got %b exp 0", pmem_read); end
    tests++; if (pmem_write !== 1'b0 || mem_resp !== 1'b0) begin fails++; $display("FAIL rst_fill outputs: wr %b resp %b exp 0", pmem_write, mem_resp); end
    mem_read = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    lat = 3;
    do_access("after_rst", 32'h104, 1'b0, '0, '0, cyc, rd);
    tests++; if (cyc != 5) begin fails++; $display("FAIL after_rst miss cycle: got %0d exp 5", cyc); end
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    tests++; if (hit_count !== 32'(exp_hit)) begin fails++; $display("FAIL hit_count: got %0d exp %0d", hit_count, exp_hit); end
    tests++; if (miss_count !== 32'(exp_miss)) begin fails++; $display("FAIL miss_count: got %0d exp %0d", miss_count, exp_miss); end
    tests++; if (wb_count !== 32'(exp_wb)) begin fails++; $display("FAIL wb_count: got %0d exp %0d", wb_count, exp_wb); end
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_cold_read();
    test_write_merge();
    test_evict();
    test_alternate();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    test_reset_mid_fill();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
